// File: rtl/horiz_counter.sv
// horiz_counter: horizontal VGA timing counter (hcount, hsync, h_video_on,
// line_tick) with a registered pixel-advance strobe.
// Ports: pixel_clock, reset (sync, active-high) in; pix_en, hcount[9:0],
//        line_tick, hsync (active-low), h_video_on out. All outputs are flops.
// Macro HORIZ_CLKDIV_EN: advance once every 4 clocks via a 2-bit divider;
// undefined, the count advances on every clock.
module horiz_counter #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48
) (
  input  logic       pixel_clock,
  input  logic       reset,
  output logic       pix_en,
  output logic [9:0] hcount,
  output logic       line_tick,
  output logic       hsync,
  output logic       h_video_on
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;

  if (H_TOTAL > 1024) begin : g_bad_total
    $error("horiz_counter: H_TOTAL exceeds 1024");
  end

  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [10:0] VIS_END  = 11'(H_ACTIVE);
  localparam logic [10:0] SYNC_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC);

  logic [9:0] hcount_q, hcount_d;
  logic       line_tick_q, line_tick_d;
  logic       hsync_q, hsync_d;
  logic       h_video_on_q, h_video_on_d;
  logic       pix_en_q, pix_en_d;
  logic       advance;

`ifdef HORIZ_CLKDIV_EN
  logic [1:0] div_q, div_d;

  // pix_en_q is high exactly while div_q == 3, so it is set from div_q == 2.
  always_comb begin
    div_d    = div_q + 2'd1;
    pix_en_d = (div_q == 2'd2);
    advance  = pix_en_q;
  end

  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      div_q <= 2'd0;
    end else begin
      div_q <= div_d;
    end
  end
`else
  always_comb begin
    pix_en_d = 1'b1;
    advance  = 1'b1;
  end
`endif

  // Decode sync/blank from the next count so they line up with hcount.
  always_comb begin
    hcount_d    = hcount_q;
    line_tick_d = 1'b0;
    if (advance) begin
      if (hcount_q == H_LAST) begin
        hcount_d    = 10'd0;
        line_tick_d = 1'b1;
      end else begin
        hcount_d = hcount_q + 10'd1;
      end
    end
    h_video_on_d = ({1'b0, hcount_d} < VIS_END);
    hsync_d      = !(({1'b0, hcount_d} >= SYNC_BEG) &&
                     ({1'b0, hcount_d} <  SYNC_END));
  end

  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      hcount_q     <= 10'd0;
      line_tick_q  <= 1'b0;
      hsync_q      <= 1'b1;
      h_video_on_q <= 1'b1;
      pix_en_q     <= 1'b0;
    end else begin
      hcount_q     <= hcount_d;
      line_tick_q  <= line_tick_d;
      hsync_q      <= hsync_d;
      h_video_on_q <= h_video_on_d;
      pix_en_q     <= pix_en_d;
    end
  end

  assign pix_en     = pix_en_q;
  assign hcount     = hcount_q;
  assign line_tick  = line_tick_q;
  assign hsync      = hsync_q;
  assign h_video_on = h_video_on_q;

endmodule

// File: tb/tb_horiz_counter.sv
// tb_horiz_counter: directed bench for horiz_counter with a reference
// model feeding an expected-value queue, compared one clock later.
module tb_horiz_counter;

  localparam int H_TOTAL = 800;
`ifdef HORIZ_CLKDIV_EN
  localparam int DIV = 4;
`else
  localparam int DIV = 1;
`endif

  typedef struct {
    int   h;
    logic tick;
    logic hs;
    logic vid;
    logic pe;
  } exp_t;

  logic       pixel_clock;
  logic       reset;
  logic       pix_en;
  logic [9:0] hcount;
  logic       line_tick;
  logic       hsync;
  logic       h_video_on;

  horiz_counter dut (
    .pixel_clock(pixel_clock),
    .reset(reset),
    .pix_en(pix_en),
    .hcount(hcount),
    .line_tick(line_tick),
    .hsync(hsync),
    .h_video_on(h_video_on)
  );

  initial pixel_clock = 1'b0;
  always #5 pixel_clock = ~pixel_clock;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  int   m_h   = 0;
  int   m_div = 0;
  logic m_pe  = 1'b0;
  int   ticks = 0;
  int   vcount = 0;
  logic prev_tick = 1'b0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Model one clock edge with the given reset and queue the result.
  task automatic model_edge(input logic r);
    exp_t e;
    logic adv;
    e.tick = 1'b0;
    if (r) begin
      m_h = 0; m_div = 0; m_pe = 1'b0;
    end else begin
`ifdef HORIZ_CLKDIV_EN
      adv   = m_pe;
      m_pe  = (m_div == 2);
      m_div = (m_div + 1) % 4;
`else
      adv  = 1'b1;
      m_pe = 1'b1;
`endif
      if (adv) begin
        if (m_h == H_TOTAL - 1) begin
          m_h = 0;
          e.tick = 1'b1;
        end else begin
          m_h = m_h + 1;
        end
      end
    end
    e.h   = m_h;
    e.hs  = !(m_h >= 656 && m_h <= 751);
    e.vid = (m_h < 640);
    e.pe  = m_pe;
    sb.push_back(e);
  endtask

  task automatic step(input logic r);
    exp_t e;
    reset = r;
    model_edge(r);
    @(posedge pixel_clock);
    #1;
    e = sb.pop_front();
    if (line_tick === 1'b1) begin
      ticks++;
      vcount = (vcount + 1) % 525;
    end
    if (hcount !== 10'(e.h))     chk("hcount", int'(hcount), e.h);
    if (line_tick !== e.tick)    chk("line_tick", int'(line_tick), int'(e.tick));
    if (hsync !== e.hs)          chk("hsync", int'(hsync), int'(e.hs));
    if (h_video_on !== e.vid)    chk("h_video_on", int'(h_video_on), int'(e.vid));
    if (pix_en !== e.pe)         chk("pix_en", int'(pix_en), int'(e.pe));
    if (prev_tick && line_tick)  chk("tick_width", 2, 1);
    prev_tick = line_tick;
    checks++;
  endtask

  initial begin
    int n;
    reset = 1'b1;
    #2;
    // Reset held three clocks.
    for (int i = 0; i < 3; i++) step(1'b1);
    chk("rst_hcount", int'(hcount), 0);
    chk("rst_hsync", int'(hsync), 1);
    chk("rst_video", int'(h_video_on), 1);
    chk("rst_tick", int'(line_tick), 0);
    chk("rst_pix_en", int'(pix_en), 0);

    // First edge after release.
    step(1'b0);
    chk("first_adv", int'(hcount), (DIV == 1) ? 1 : 0);

    // Two lines of free run, counting ticks.
    ticks = 0;
    for (int i = 1; i < 2 * H_TOTAL * DIV; i++) step(1'b0);
    chk("two_line_ticks", ticks, 2);

    // Walk to 799 with an advance due next edge, then reset on that edge.
    n = 0;
`ifdef HORIZ_CLKDIV_EN
    while (!(m_h == H_TOTAL - 1 && m_pe) && n < 4 * H_TOTAL * DIV) begin
`else
    while (!(m_h == H_TOTAL - 1) && n < 4 * H_TOTAL * DIV) begin
`endif
      step(1'b0);
      n++;
    end
    chk("reach_799", int'(hcount), H_TOTAL - 1);
    step(1'b1);
    chk("wrap_rst_hcount", int'(hcount), 0);
    chk("wrap_rst_tick", int'(line_tick), 0);

    // Next tick only after a full line of advances.
    ticks = 0;
    for (int i = 0; i < H_TOTAL * DIV - 1; i++) step(1'b0);
    chk("no_early_tick", ticks, 0);
    step(1'b0);
    chk("tick_after_line", int'(line_tick), 1);
    chk("tick_hcount0", int'(hcount), 0);

    // Vertical counter driven by line_tick over ten lines.
    vcount = 0;
    ticks  = 0;
    for (int i = 0; i < 10 * H_TOTAL * DIV; i++) step(1'b0);
    chk("vcount_10", vcount, 10);
    chk("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
